irq_pending_latch: RTL
======================

# irq_pending_latch

Pending-request capture and dispatch stage placed directly upstream of the 8-to-3 priority encoder (`penc8x3`).
- Synchronizes eight asynchronous request lines and latches each one as a sticky pending bit.
- Presents the masked pending vector to the encoder and takes back the encoded index and valid flag.
- Offers the winning index to a consumer over a valid/ready handshake, then holds off further dispatch until end-of-interrupt.

## Interface
- `SYNC_STAGES`, default 2 — synchronizer depth on `req_in`; legal values ≥ 2.
- `EDGE_MODE`, default 1 — 1 = rising-edge-triggered pending; 0 = level-triggered (pending set while the synchronized level is high).
- `clk` in 1 — single clock; all state is rising-edge.
- `rst_n` in 1 — reset, asynchronous assert, active-low.
- `req_in` in 8 — raw asynchronous request lines.
- `mask` in 8 — 1 = source masked from dispatch; masking does not block latching.
- `pend_vec` out 8 — `pending & ~mask`, combinational; drives the encoder `in`.
- `enc_idx` in 3 — encoder `out`, combinational return path.
- `enc_valid` in 1 — encoder `valid`.
- `irq_valid` out 1 — dispatched index available.
- `irq_ready` in 1 — consumer accepts `irq_id`.
- `irq_id` out 3 — dispatched source index.
- `eoi` in 1 — single-cycle end-of-interrupt pulse from the consumer.
- `in_service` out 1 — high from acceptance until `eoi`.
- `ovf` out 8 — sticky per-source overrun flags.
- `ovf_clr` in 8 — write-1-to-clear for `ovf`.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops per bit, followed by one history flop for edge detect.
- **Set condition:**
  - `EDGE_MODE=1`: synchronized rise.
  - `EDGE_MODE=0`: synchronized level high.
- **Pending bit i:**
  - Set on the set condition.
  - Cleared when a handshake completes on `irq_id == i`.
  - If set and clear hit the same bit in the same cycle, set wins: the bit stays 1 and no overrun is flagged.
- **Overrun:**
  - `ovf[i]` sets when the set condition occurs while `pending[i]` is already 1 and bit i is not being cleared that cycle.
  - Only in `EDGE_MODE=1`; in level mode `ovf` stays 0.
  - `ovf_clr[i]` clears it; if set and clear occur together, set wins.
- **FSM states:** IDLE, OFFER, SERVICE.
  - IDLE: when `enc_valid`=1, register `irq_id <= enc_idx` → OFFER.
  - OFFER: `irq_valid`=1 and `irq_id` held stable. On `irq_ready`=1, clear `pending[irq_id]` → SERVICE. `mask` changes during OFFER do not retract the offer.
  - SERVICE: `in_service`=1. On `eoi`=1 → IDLE.
- `eoi` outside SERVICE is ignored.
- `irq_ready` outside OFFER is ignored.
- `enc_idx` and `enc_valid` are sampled only in IDLE.
- Pending bits keep latching in every state.

## Timing
- **Reset values:**
  - All synchronizer and history flops 0.
  - `pending`=0, so `pend_vec`=0.
  - `ovf`=0, `irq_valid`=0, `irq_id`=0, `in_service`=0, FSM = IDLE.
- Reset asserted mid-operation: immediate return to the reset values above, including dropping a live offer.
- Deassertion takes effect at the first rising edge after `rst_n` goes high.
- **Latency, `SYNC_STAGES`=2 (cycle numbers are rising `clk` edges):**
  - `req_in` first sampled high at edge k → `pending` set after edge k+2 → `irq_valid` high after edge k+3.
  - Each extra sync stage adds one cycle.
- **Handshake:**
  - Transfer occurs on an edge where `irq_valid`=1 and `irq_ready`=1.
  - `irq_valid` falls and `in_service` rises after that edge.
- **Back-to-back dispatch:** `eoi` at edge e → IDLE after e → next `irq_valid` after e+1 if `enc_valid` is high. Minimum spacing is one idle cycle.
- **Empty:** `enc_valid`=0 in IDLE keeps the FSM in IDLE.
- **All masked:** `pend_vec`=0 and nothing is dispatched; pending bits are retained and dispatch once unmasked.

## Test plan
- **Reset:** assert `rst_n`=0 mid-OFFER with `irq_id`=5 → `irq_valid`, `in_service`, `pend_vec` and `ovf` go to 0 immediately; FSM is IDLE after release.
- **Single request:** pulse `req_in`=8'h10 for 2 cycles with `irq_ready`=1 → `pend_vec`=8'h10 at k+3; `irq_valid`=1 with `irq_id`=4 at k+4; `pend_vec`=0 after acceptance; `in_service`=1 until `eoi`.
- **Priority:** `req_in`=8'h81 together → `irq_id`=7 first; after `eoi`, `irq_id`=0; pending empties.
- **Masking:** set pending 8'h04 with `mask`=8'h04 → no `irq_valid` for 20 cycles; clear `mask` → `irq_id`=2 dispatched.
- **Overrun and simultaneity:**
  - A second rise on bit 3 while pending, before acceptance → `ovf`=8'h08.
  - `ovf_clr`=8'h08 → 0.
  - A rise on bit 3 on the same edge as its acceptance → `pending[3]` stays 1 and `ovf` stays 0.
- **Handshake stall:** hold `irq_ready`=0 for 10 cycles while raising a higher source → `irq_id` stays unchanged; `eoi` during OFFER is ignored.

Source files
------------

// File: rtl/irq_pending_latch.sv
// Request synchronizer, sticky pending latch and valid/ready dispatch stage
// wrapped around an external 8-to-3 priority encoder.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    output logic [7:0] pend_vec,
    input  logic [2:0] enc_idx,
    input  logic       enc_valid,
    output logic       irq_valid,
    input  logic       irq_ready,
    output logic [2:0] irq_id,
    input  logic       eoi,
    output logic       in_service,
    output logic [7:0] ovf,
    input  logic [7:0] ovf_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state_q;
    logic       irq_valid_q;
    logic [2:0] irq_id_q;
    logic       in_service_q;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];
    logic [7:0] hist_q, hist_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] ovf_q, ovf_d;

    logic [7:0] sync_out;
    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] ovf_set;
    logic       accept;

    always_comb begin
        sync_d[0] = req_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign hist_d   = sync_out;
    assign accept   = (state_q == OFFER) && irq_ready;

    always_comb begin
        if (EDGE_MODE != 0) begin
            set_vec = sync_out & ~hist_q;
        end else begin
            set_vec = sync_out;
        end
    end

    always_comb begin
        clr_vec = 8'h00;
        if (accept) begin
            clr_vec = 8'h01 << irq_id_q;
        end
    end

    // A new request on the bit being accepted re-arms it instead of flagging overrun.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | set_vec;
        ovf_set   = 8'h00;
        if (EDGE_MODE != 0) begin
            ovf_set = set_vec & pending_q & ~clr_vec;
        end
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
            hist_q    <= 8'h00;
            pending_q <= 8'h00;
            ovf_q     <= 8'h00;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            hist_q    <= hist_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // Encoder result is only looked at in IDLE; the offered index is frozen until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= 3'd0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_valid) begin
                        irq_id_q    <= enc_idx;
                        irq_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (irq_ready) begin
                        irq_valid_q  <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        in_service_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    irq_valid_q  <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign pend_vec   = pending_q & ~mask;
    assign irq_valid  = irq_valid_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign ovf        = ovf_q;

endmodule
